// File: rtl/sha_512_pad.sv
// SHA-512 family message padder: packs 64-bit words into 1024-bit blocks, appends
// the 0x80 / zero-fill / 128-bit length trailer, sequences blocks into the core and truncates the digest.
module sha_512_pad #(
    parameter int LEN_W = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [63:0]   s_data,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic          s_last,
    input  logic [3:0]    s_bytes,
    input  logic [1:0]    op,
    output logic [1023:0] m_data,
    output logic [127:0]  m_index,
    output logic [1:0]    m_operation,
    output logic          m_enable,
    input  logic [511:0]  core_hash,
    input  logic          core_ready,
    output logic [511:0]  hash,
    output logic          hash_valid,
    output logic          busy
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_FILL = 3'd1,
        ST_PAD  = 3'd2,
        ST_SEND = 3'd3,
        ST_WAIT = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    state_t             state_r;
    logic [1023:0]      buf_r;
    logic [3:0]         word_idx_r;
    logic [LEN_W-1:0]   len_r;
    logic [7:0]         pad_pos_r;
    logic               lastblk_r;
    logic               pend_r;
    logic               pad80_r;
    logic               s_ready_r;
    logic               m_enable_r;
    logic               hash_valid_r;
    logic               busy_r;
    logic [127:0]       m_index_r;
    logic [1:0]         op_r;
    logic [511:0]       hash_r;

    logic               accept_s;
    logic [3:0]         bytes_s;
    logic [6:0]         inc_bits_s;
    logic [LEN_W-1:0]   len_base_s;
    logic [LEN_W-1:0]   len_next_s;
    logic [7:0]         pad_pos_next_s;
    logic [127:0]       len128_s;
    logic               len_fits_s;
    logic [1023:0]      pad_fill_s;
    logic [1023:0]      pad_blk_s;
    logic [1023:0]      pad_only_s;

    // Keep the top 224/256/384/512 bits of the core hash according to the digest variant.
    function automatic logic [511:0] digest_mask(input logic [1:0] sel);
        logic [511:0] m;
        case (sel)
            2'd0:    m = {{224{1'b1}}, {288{1'b0}}};
            2'd1:    m = {{256{1'b1}}, {256{1'b0}}};
            2'd2:    m = {{384{1'b1}}, {128{1'b0}}};
            default: m = {512{1'b1}};
        endcase
        return m;
    endfunction

    // Handshake, byte count and length bookkeeping for the word on the input.
    always_comb begin
        accept_s = s_valid & s_ready_r;
        if (s_last) begin
            if (s_bytes > 4'd8) begin
                bytes_s = 4'd8;
            end else begin
                bytes_s = s_bytes;
            end
        end else begin
            bytes_s = 4'd8;
        end
        inc_bits_s = {bytes_s, 3'b000};
        if (state_r == ST_IDLE) begin
            len_base_s = {LEN_W{1'b0}};
        end else begin
            len_base_s = len_r;
        end
        len_next_s     = len_base_s + LEN_W'(inc_bits_s);
        pad_pos_next_s = {1'b0, word_idx_r, 3'b000} + {4'b0000, bytes_s};
    end

    // Padding of the current buffer, plus the standalone pad-only block.
    always_comb begin
        len128_s   = 128'(len_r);
        len_fits_s = (pad_pos_r <= 8'd111);
        pad_fill_s = buf_r;
        // Byte b lives in word b/8, most significant byte first.
        for (int b = 0; b < 128; b++) begin
            if (b == int'(pad_pos_r)) begin
                pad_fill_s[(b / 8) * 64 + (7 - (b % 8)) * 8 +: 8] = 8'h80;
            end else if (b > int'(pad_pos_r)) begin
                pad_fill_s[(b / 8) * 64 + (7 - (b % 8)) * 8 +: 8] = 8'h00;
            end else begin
                pad_fill_s[(b / 8) * 64 + (7 - (b % 8)) * 8 +: 8] = buf_r[(b / 8) * 64 + (7 - (b % 8)) * 8 +: 8];
            end
        end
        if (len_fits_s) begin
            pad_blk_s = {len128_s[63:0], len128_s[127:64], pad_fill_s[895:0]};
        end else begin
            pad_blk_s = pad_fill_s;
        end
        pad_only_s = {len128_s[63:0], len128_s[127:64], 896'd0};
        if (!pad80_r) begin
            pad_only_s[63:56] = 8'h80;
        end else begin
            pad_only_s[63:56] = 8'h00;
        end
    end

    // Main sequencer: fill, pad, send, wait for the core, present the digest.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            buf_r        <= 1024'd0;
            word_idx_r   <= 4'd0;
            len_r        <= {LEN_W{1'b0}};
            pad_pos_r    <= 8'd0;
            lastblk_r    <= 1'b0;
            pend_r       <= 1'b0;
            pad80_r      <= 1'b0;
            s_ready_r    <= 1'b0;
            m_enable_r   <= 1'b0;
            hash_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            m_index_r    <= 128'd0;
            op_r         <= 2'd0;
            hash_r       <= 512'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        buf_r      <= {960'd0, s_data};
                        word_idx_r <= 4'd1;
                        len_r      <= len_next_s;
                        pad_pos_r  <= pad_pos_next_s;
                        op_r       <= op;
                        m_index_r  <= 128'd1;
                        busy_r     <= 1'b1;
                        if (s_last) begin
                            s_ready_r <= 1'b0;
                            state_r   <= ST_PAD;
                        end else begin
                            s_ready_r <= 1'b1;
                            state_r   <= ST_FILL;
                        end
                    end else begin
                        s_ready_r <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (accept_s) begin
                        buf_r[{word_idx_r, 6'b000000} +: 64] <= s_data;
                        word_idx_r <= word_idx_r + 4'd1;
                        len_r      <= len_next_s;
                        pad_pos_r  <= pad_pos_next_s;
                        if (s_last) begin
                            s_ready_r <= 1'b0;
                            state_r   <= ST_PAD;
                        end else if (word_idx_r == 4'd15) begin
                            s_ready_r  <= 1'b0;
                            lastblk_r  <= 1'b0;
                            pend_r     <= 1'b0;
                            m_enable_r <= 1'b1;
                            state_r    <= ST_SEND;
                        end else begin
                            state_r <= ST_FILL;
                        end
                    end else begin
                        state_r <= ST_FILL;
                    end
                end
                ST_PAD: begin
                    buf_r      <= pad_blk_s;
                    lastblk_r  <= len_fits_s;
                    pend_r     <= ~len_fits_s;
                    pad80_r    <= (pad_pos_r < 8'd128);
                    m_enable_r <= 1'b1;
                    state_r    <= ST_SEND;
                end
                ST_SEND: begin
                    m_enable_r <= 1'b0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_ready) begin
                        if (lastblk_r) begin
                            hash_r       <= core_hash & digest_mask(op_r);
                            hash_valid_r <= 1'b1;
                            state_r      <= ST_DONE;
                        end else if (pend_r) begin
                            buf_r      <= pad_only_s;
                            pad80_r    <= 1'b1;
                            pend_r     <= 1'b0;
                            lastblk_r  <= 1'b1;
                            m_index_r  <= m_index_r + 128'd1;
                            m_enable_r <= 1'b1;
                            state_r    <= ST_SEND;
                        end else begin
                            buf_r      <= 1024'd0;
                            word_idx_r <= 4'd0;
                            m_index_r  <= m_index_r + 128'd1;
                            s_ready_r  <= 1'b1;
                            state_r    <= ST_FILL;
                        end
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    hash_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    word_idx_r   <= 4'd0;
                    s_ready_r    <= 1'b1;
                    state_r      <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign s_ready     = s_ready_r;
    assign m_data      = buf_r;
    assign m_index     = m_index_r;
    assign m_operation = op_r;
    assign m_enable    = m_enable_r;
    assign hash        = hash_r;
    assign hash_valid  = hash_valid_r;
    assign busy        = busy_r;

endmodule
